// File: rtl/spi_master_v2.sv
// Full-duplex SPI master with valid/ready word interface, CPOL/CPHA modes,
// burst frames (CS held between words) and an inter-frame CS gap.
module spi_master_v2 #(
  parameter int CLK_FRE  = 100_000_000,
  parameter int SPI_FRE  = 1_000_000,
  parameter int DATA_W   = 8,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int CS_NUM   = 4,
  parameter int CS_SEL_W = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                clk_i,
  input  logic                rst,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_last,
  input  logic [CS_SEL_W-1:0] cs_sel,
  output logic                rx_valid,
  output logic [DATA_W-1:0]   rx_data,
  output logic                busy,
  output logic [CS_NUM-1:0]   spi_cs_n,
  output logic                spi_sck,
  output logic                spi_sdo,
  input  logic                spi_sdi
);

  localparam int HALF  = CLK_FRE / (2 * SPI_FRE);
  localparam int DIV_W = $clog2(HALF) + 1;
  localparam int BIT_W = $clog2(2 * DATA_W) + 1;
  localparam int GAP_W = $clog2(CS_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF - 1);
  localparam logic [BIT_W-1:0] EDGE_LAST = BIT_W'(2 * DATA_W);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_NEXT, S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_edge;
  logic [GAP_W-1:0]  r_gap;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic              r_last;
  logic [CS_NUM-1:0] r_cs_n;
  logic              r_sck;
  logic              r_sdo;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_data;

  logic              w_accept;
  logic              w_div_done;
  logic [BIT_W-1:0]  w_edge_num;
  logic              w_sck_edge;
  logic              w_sample;
  logic              w_drive;
  logic              w_final;
  logic [CS_NUM-1:0] w_cs_dec;
  logic [DATA_W-1:0] w_rx_word;
  logic [DATA_W-1:0] w_tx_load;

  // An out-of-range cs_sel matches no line, so every CS stays high.
  genvar gi;
  generate
    for (gi = 0; gi < CS_NUM; gi++) begin : g_cs_dec
      assign w_cs_dec[gi] = (cs_sel != CS_SEL_W'(gi));
    end
  endgenerate

  assign tx_ready   = (r_state == S_IDLE) || (r_state == S_NEXT);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = tx_valid && tx_ready;
  assign w_div_done = (r_div == DIV_LAST);
  assign w_edge_num = r_edge + 1'b1;
  assign w_sck_edge = (r_state == S_SHIFT) && w_div_done;
  assign w_sample   = w_sck_edge && (w_edge_num[0] ^ CPHA);
  assign w_drive    = w_sck_edge && (CPHA ? w_edge_num[0]
                                          : (!w_edge_num[0] && (w_edge_num != EDGE_LAST)));
  assign w_final    = w_sck_edge && (w_edge_num == EDGE_LAST);

  // With CPHA=1 the last sample lands on the final edge itself, so it is merged in here.
  assign w_rx_word  = CPHA ? {r_rx_sh[DATA_W-2:0], spi_sdi} : r_rx_sh;
  // With CPHA=0 the MSB goes straight to spi_sdo, so the shifter starts one bit ahead.
  assign w_tx_load  = CPHA ? tx_data : {tx_data[DATA_W-2:0], 1'b0};

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_LEAD;
      S_LEAD:  if (w_div_done) w_state_next = S_SHIFT;
      S_SHIFT: if (w_final) w_state_next = S_TRAIL;
      S_TRAIL: if (w_div_done) w_state_next = r_last ? S_GAP : S_NEXT;
      S_NEXT:  if (w_accept) w_state_next = S_LEAD;
      S_GAP:   if (r_gap == GAP_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_edge     <= '0;
      r_gap      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_last     <= 1'b0;
      r_cs_n     <= '1;
      r_sck      <= CPOL;
      r_sdo      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      // The divider restarts on every state change so each phase is exactly HALF long.
      if ((w_state_next != r_state) || w_div_done) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_gap <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
      if (w_accept) begin
        r_tx_sh <= w_tx_load;
        r_last  <= tx_last;
        r_edge  <= '0;
        if (!CPHA) r_sdo <= tx_data[DATA_W-1];
        if (r_state == S_IDLE) r_cs_n <= w_cs_dec;
      end
      if (w_sck_edge) begin
        r_sck  <= ~r_sck;
        r_edge <= w_edge_num;
      end
      if (w_sample) r_rx_sh <= {r_rx_sh[DATA_W-2:0], spi_sdi};
      if (w_drive) begin
        r_sdo   <= r_tx_sh[DATA_W-1];
        r_tx_sh <= r_tx_sh << 1;
      end
      if (w_final) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_rx_word;
      end
      if ((r_state == S_TRAIL) && w_div_done && r_last) begin
        r_cs_n <= '1;
        r_sdo  <= 1'b0;
      end
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign spi_cs_n = r_cs_n;
  assign spi_sck  = r_sck;
  assign spi_sdo  = r_sdo;

endmodule

// File: tb/tb_spi_master_v2.sv
// Directed bench for spi_master_v2: three instances (mode 0 / mode 3 / 16-bit)
// with a scoreboard of expected received words.
module tb_spi_master_v2;

  localparam int LIM = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // u0: 8-bit, HALF=2, mode 0, loopback
  logic       tx_valid0 = 0, tx_last0 = 0, tx_ready0, rx_valid0, busy0, sck0, sdo0, sdi0;
  logic [7:0] tx_data0 = 0, rx_data0;
  logic [1:0] cs_sel0 = 0;
  logic [3:0] cs_n0;
  assign sdi0 = sdo0;

  // u1: 8-bit, HALF=3, CPOL=1 CPHA=1, slave model on sdi
  logic       tx_valid1 = 0, tx_last1 = 0, tx_ready1, rx_valid1, busy1, sck1, sdo1;
  logic       sdi1 = 0;
  logic [7:0] tx_data1 = 0, rx_data1;
  logic [1:0] cs_sel1 = 0;
  logic [3:0] cs_n1;

  // u2: 16-bit, HALF=1, mode 0, loopback
  logic        tx_valid2 = 0, tx_last2 = 0, tx_ready2, rx_valid2, busy2, sck2, sdo2, sdi2;
  logic [15:0] tx_data2 = 0, rx_data2;
  logic [1:0]  cs_sel2 = 0;
  logic [3:0]  cs_n2;
  assign sdi2 = sdo2;

  spi_master_v2 #(.CLK_FRE(100_000_000), .SPI_FRE(25_000_000), .DATA_W(8),
                  .CPOL(1'b0), .CPHA(1'b0), .CS_NUM(4), .CS_SEL_W(2), .CS_GAP(4)) u0 (
    .clk_i(clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
    .tx_last(tx_last0), .cs_sel(cs_sel0), .rx_valid(rx_valid0), .rx_data(rx_data0),
    .busy(busy0), .spi_cs_n(cs_n0), .spi_sck(sck0), .spi_sdo(sdo0), .spi_sdi(sdi0));

  spi_master_v2 #(.CLK_FRE(60_000_000), .SPI_FRE(10_000_000), .DATA_W(8),
                  .CPOL(1'b1), .CPHA(1'b1), .CS_NUM(4), .CS_SEL_W(2), .CS_GAP(4)) u1 (
    .clk_i(clk), .rst(rst), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
    .tx_last(tx_last1), .cs_sel(cs_sel1), .rx_valid(rx_valid1), .rx_data(rx_data1),
    .busy(busy1), .spi_cs_n(cs_n1), .spi_sck(sck1), .spi_sdo(sdo1), .spi_sdi(sdi1));

  spi_master_v2 #(.CLK_FRE(100_000_000), .SPI_FRE(50_000_000), .DATA_W(16),
                  .CPOL(1'b0), .CPHA(1'b0), .CS_NUM(4), .CS_SEL_W(2), .CS_GAP(4)) u2 (
    .clk_i(clk), .rst(rst), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .tx_last(tx_last2), .cs_sel(cs_sel2), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .busy(busy2), .spi_cs_n(cs_n2), .spi_sck(sck2), .spi_sdo(sdo2), .spi_sdi(sdi2));

  // Scoreboard: expected words pushed on accept, received words logged by the monitors.
  logic [31:0] q0[$], q1[$], q2[$];
  logic [31:0] rxlog0[0:63], rxlog1[0:63], rxlog2[0:63];
  int rd0 = 0, rd1 = 0, rd2 = 0;

  logic [3:0] exp_cs0 = 4'hF;
  int rise0 = 0, csm0 = 0, cslo0 = 0, gap0 = 0, rxv0 = 0;
  logic p_sck0;
  always @(negedge clk) begin
    p_sck0 <= sck0;
    if (sck0 === 1'b1 && p_sck0 === 1'b0) rise0 <= rise0 + 1;
    if (cs_n0 === exp_cs0) csm0 <= csm0 + 1;
    if (cs_n0 !== 4'hF) cslo0 <= cslo0 + 1;
    if (busy0 === 1'b1 && cs_n0 === 4'hF) gap0 <= gap0 + 1;
    if (rx_valid0 === 1'b1) begin
      rxlog0[rxv0 % 64] <= {24'h0, rx_data0};
      rxv0 <= rxv0 + 1;
    end
  end

  int rxv1 = 0, sdo_bad1 = 0, fcnt1 = 0;
  logic p_sck1, p_sdo1;
  logic [7:0] mosi1 = 0;
  logic [7:0] slave_word1 = 8'hC3;
  always @(negedge clk) begin
    p_sck1 <= sck1;
    p_sdo1 <= sdo1;
    if (cs_n1[0] === 1'b0 && sdo1 !== p_sdo1 && !(p_sck1 === 1'b1 && sck1 === 1'b0))
      sdo_bad1 <= sdo_bad1 + 1;
    if (rx_valid1 === 1'b1) begin
      rxlog1[rxv1 % 64] <= {24'h0, rx_data1};
      rxv1 <= rxv1 + 1;
    end
  end
  always @(posedge sck1) if (cs_n1[0] === 1'b0) mosi1 <= {mosi1[6:0], sdo1};
  // Slave changes its output on the leading (falling) edge for mode 3.
  always @(negedge sck1 or posedge cs_n1[0]) begin
    if (cs_n1[0]) fcnt1 <= 0;
    else if (fcnt1 < 8) begin
      sdi1  <= slave_word1[3'(7 - fcnt1)];
      fcnt1 <= fcnt1 + 1;
    end
  end

  int edges2 = 0, busyc2 = 0, rxv2 = 0;
  logic p_sck2;
  always @(negedge clk) begin
    p_sck2 <= sck2;
    if ((sck2 ^ p_sck2) === 1'b1) edges2 <= edges2 + 1;
    if (busy2 === 1'b1) busyc2 <= busyc2 + 1;
    if (rx_valid2 === 1'b1) begin
      rxlog2[rxv2 % 64] <= {16'h0, rx_data2};
      rxv2 <= rxv2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    logic b = 1'b1;
    while (b && n < LIM) begin
      @(negedge clk);
      n++;
      b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
    end
    chk("idle_timeout", 32'(n < LIM), 32'd1);
    @(negedge clk);
    #1;
  endtask

  // Called at a negedge; presents a word to u0 and returns at the negedge after accept.
  task automatic send0(input logic [7:0] d, input logic last, input logic [1:0] sel, input bit push);
    int n = 0;
    tx_valid0 = 1'b1; tx_data0 = d; tx_last0 = last; cs_sel0 = sel;
    while (!tx_ready0 && n < LIM) begin @(negedge clk); n++; end
    chk("accept_timeout0", 32'(n < LIM), 32'd1);
    if (push) q0.push_back({24'h0, d});
    $display("send0 data=0x%02h last=%0d sel=%0d", d, last, sel);
    @(negedge clk);
    tx_valid0 = 1'b0;
  endtask

  task automatic drain(input int which);
    logic [31:0] e;
    if (which == 0) while (rd0 < rxv0) begin
      e = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
      chk("rx0", rxlog0[rd0 % 64], e);
      $display("rx0 data=0x%0h expected=0x%0h", rxlog0[rd0 % 64], e);
      rd0++;
    end
    if (which == 1) while (rd1 < rxv1) begin
      e = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_BEEF;
      chk("rx1", rxlog1[rd1 % 64], e);
      $display("rx1 data=0x%0h expected=0x%0h", rxlog1[rd1 % 64], e);
      rd1++;
    end
    if (which == 2) while (rd2 < rxv2) begin
      e = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD_BEEF;
      chk("rx2", rxlog2[rd2 % 64], e);
      $display("rx2 data=0x%0h expected=0x%0h", rxlog2[rd2 % 64], e);
      rd2++;
    end
  endtask

  int s_rise, s_csm, s_cslo, s_gap, s_rxv, s_edges, s_busy, n;

  initial begin
    // Reset state, and a handshake attempted under reset must be ignored.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", cs_n0, 4'hF);
    chk("rst_sck0", sck0, 1'b0);
    chk("rst_sck1", sck1, 1'b1);
    chk("rst_sdo", sdo0, 1'b0);
    chk("rst_rx_valid", rx_valid0, 1'b0);
    chk("rst_rx_data", rx_data0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_tx_ready", tx_ready0, 1'b1);
    tx_valid0 = 1'b1; tx_data0 = 8'h77;
    repeat (2) @(negedge clk);
    tx_valid0 = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_wins_busy", busy0, 1'b0);

    // 1: single mode-0 loopback word
    s_rise = rise0; s_csm = csm0; s_cslo = cslo0; s_gap = gap0; s_rxv = rxv0;
    exp_cs0 = 4'b1110;
    @(negedge clk);
    send0(8'hA5, 1'b1, 2'd0, 1'b1);
    wait_idle(0);
    chk("t1_rises", rise0 - s_rise, 8);
    chk("t1_cs_low", csm0 - s_csm, 36);
    chk("t1_any_cs_low", cslo0 - s_cslo, 36);
    chk("t1_gap", gap0 - s_gap, 4);
    chk("t1_rxv_cycles", rxv0 - s_rxv, 1);
    drain(0);

    // 2: mode 3 against the slave model
    chk("t2_sck_idle_before", sck1, 1'b1);
    s_rxv = rxv1;
    tx_valid1 = 1'b1; tx_data1 = 8'h3C; tx_last1 = 1'b1; cs_sel1 = 2'd0;
    n = 0;
    while (!tx_ready1 && n < LIM) begin @(negedge clk); n++; end
    q1.push_back(32'h0000_00C3);
    $display("send1 data=0x3c last=1 sel=0");
    @(negedge clk);
    tx_valid1 = 1'b0;
    wait_idle(1);
    chk("t2_mosi", mosi1, 8'h3C);
    chk("t2_sdo_edges", sdo_bad1, 0);
    chk("t2_rxv_cycles", rxv1 - s_rxv, 1);
    chk("t2_sck_idle_after", sck1, 1'b1);
    drain(1);

    // 3: three-word burst on cs_sel=2, cs_sel changed mid-burst
    s_csm = csm0; s_cslo = cslo0; s_gap = gap0; s_rxv = rxv0;
    exp_cs0 = 4'b1011;
    send0(8'h11, 1'b0, 2'd2, 1'b1);
    send0(8'h22, 1'b0, 2'd1, 1'b1);
    send0(8'h33, 1'b1, 2'd1, 1'b1);
    wait_idle(0);
    chk("t3_cs_match", csm0 - s_csm, 110);
    chk("t3_cs_low", cslo0 - s_cslo, 110);
    chk("t3_gap", gap0 - s_gap, 4);
    chk("t3_rxv_cycles", rxv0 - s_rxv, 3);
    drain(0);

    // 4: 16-bit, HALF=1
    s_edges = edges2; s_busy = busyc2; s_rxv = rxv2;
    tx_valid2 = 1'b1; tx_data2 = 16'hBEEF; tx_last2 = 1'b1; cs_sel2 = 2'd1;
    n = 0;
    while (!tx_ready2 && n < LIM) begin @(negedge clk); n++; end
    q2.push_back(32'h0000_BEEF);
    $display("send2 data=0xbeef last=1 sel=1");
    @(negedge clk);
    tx_valid2 = 1'b0;
    wait_idle(2);
    chk("t4_edges", edges2 - s_edges, 32);
    chk("t4_busy", busyc2 - s_busy, 38);
    chk("t4_rxv_cycles", rxv2 - s_rxv, 1);
    drain(2);

    // 5: reset mid-SHIFT after edge 5, then a clean word
    s_rise = rise0; s_rxv = rxv0;
    exp_cs0 = 4'b1110;
    send0(8'hFF, 1'b1, 2'd0, 1'b0);
    n = 0;
    while (rise0 < s_rise + 3 && n < LIM) begin @(negedge clk); n++; end
    chk("t5_edge_timeout", 32'(n < LIM), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_cs_n", cs_n0, 4'hF);
    chk("t5_sck", sck0, 1'b0);
    chk("t5_sdo", sdo0, 1'b0);
    chk("t5_busy", busy0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_no_rxv", rxv0 - s_rxv, 0);
    send0(8'h5A, 1'b1, 2'd0, 1'b1);
    wait_idle(0);
    chk("t5_rxv_after", rxv0 - s_rxv, 1);
    drain(0);

    // 6: tx_valid held with changing data; only the first NEXT cycle accepts
    s_csm = csm0; s_gap = gap0; s_rxv = rxv0;
    exp_cs0 = 4'b1101;
    @(negedge clk);
    tx_valid0 = 1'b1; tx_data0 = 8'h81; tx_last0 = 1'b0; cs_sel0 = 2'd1;
    q0.push_back(32'h81);
    $display("send0 data=0x81 last=0 sel=1");
    @(negedge clk);
    tx_last0 = 1'b1; cs_sel0 = 2'd3;
    n = 0;
    while (!tx_ready0 && n < LIM) begin
      tx_data0 = 8'h40 + 8'(n);
      @(negedge clk);
      n++;
    end
    chk("t6_accept_timeout", 32'(n < LIM), 32'd1);
    q0.push_back({24'h0, tx_data0});
    $display("send0 data=0x%02h last=1 (held valid)", tx_data0);
    @(negedge clk);
    tx_valid0 = 1'b0;
    wait_idle(0);
    chk("t6_cs_match", csm0 - s_csm, 73);
    chk("t6_gap", gap0 - s_gap, 4);
    chk("t6_rxv_cycles", rxv0 - s_rxv, 2);
    drain(0);

    chk("sb0_left", q0.size(), 0);
    chk("sb1_left", q1.size(), 0);
    chk("sb2_left", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
